// File: rtl/pipeline_hazard_ctrl.sv
// Purpose : IF/ID + PC sequencer; detects load-use hazards and taken branches, drives enables/flush/bubble.
// Latency : control outputs are combinational from state + inputs (zero cycles); state/counters update on clk.
// Backpres: ext_stall freezes PC and IF/ID (and freezes a pending stall count); a taken branch overrides everything.
//
// Ports:
//   clk, reset                  rising-edge clock, asynchronous active-low reset
//   id_rn/id_rm (+ _used)       ID-stage source registers and their read qualifiers
//   ex_mem_read, ex_rd          EX-stage load flag and destination register
//   br_taken, ext_stall         branch resolved taken, external freeze request
//   pc_en, ifid_en              PC / IF/ID load enables
//   ifid_flush, idex_bubble     zero IF/ID contents, zero ID/EX control bits
//   state                       0 RUN, 1 STALL, 2 FLUSH
//   stall_count, flush_count    saturating counts of pc_en=0 / ifid_flush=1 cycles
module pipeline_hazard_ctrl #(
    parameter int REG_W        = 5,
    parameter int ZERO_REG     = 31,
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_rn_used,
    input  logic             id_rm_used,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             br_taken,
    input  logic             ext_stall,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int MAXC  = (STALL_CYCLES > FLUSH_CYCLES) ? STALL_CYCLES : FLUSH_CYCLES;
    localparam int CYC_W = $clog2(MAXC + 1);

    localparam logic [CYC_W-1:0] STALL_LOAD = CYC_W'(STALL_CYCLES - 1);
    localparam logic [CYC_W-1:0] FLUSH_LOAD = CYC_W'(FLUSH_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_ONE    = CYC_W'(1);
    localparam logic [REG_W-1:0] ZERO_IDX   = REG_W'(ZERO_REG);

    // Control word: {pc_en, ifid_en, ifid_flush, idex_bubble}
    localparam logic [3:0] CTL_PASS  = 4'b1100;
    localparam logic [3:0] CTL_HOLD  = 4'b0001;
    localparam logic [3:0] CTL_FLUSH = 4'b1111;
    localparam logic [3:0] CTL_SAFE  = 4'b0011;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2,
        S_ILL   = 2'd3
    } state_t;

    state_t           state_q, nxt_state;
    logic [CYC_W-1:0] cnt_q, nxt_cnt;
    logic [3:0]       ctl;
    logic             hazard;

    // The zero register is never really written, so a load targeting it cannot create a dependency.
    assign hazard = ex_mem_read && (ex_rd != ZERO_IDX) &&
                    ((id_rn_used && (id_rn == ex_rd)) || (id_rm_used && (id_rm == ex_rd)));

    always_comb begin
        ctl       = CTL_PASS;
        nxt_state = state_q;
        nxt_cnt   = cnt_q;
        if (state_q == S_ILL) begin
            // Unreachable encoding: keep the pipe quiet for one cycle and recover to RUN.
            ctl       = CTL_SAFE;
            nxt_state = S_RUN;
            nxt_cnt   = '0;
        end else if (br_taken) begin
            // A taken branch wins in every legal state, aborting any stall and restarting any flush.
            ctl = CTL_FLUSH;
            if (FLUSH_CYCLES > 1) begin
                nxt_state = S_FLUSH;
                nxt_cnt   = FLUSH_LOAD;
            end else begin
                nxt_state = S_RUN;
                nxt_cnt   = '0;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    if (ext_stall) begin
                        ctl = CTL_HOLD;
                    end else if (hazard) begin
                        ctl = CTL_HOLD;
                        if (STALL_CYCLES > 1) begin
                            nxt_state = S_STALL;
                            nxt_cnt   = STALL_LOAD;
                        end
                    end
                end
                S_STALL: begin
                    ctl = CTL_HOLD;
                    // A memory freeze pauses the stall countdown rather than consuming it.
                    if (!ext_stall) begin
                        if (cnt_q == CYC_ONE) begin
                            nxt_state = S_RUN;
                            nxt_cnt   = '0;
                        end else begin
                            nxt_cnt = cnt_q - CYC_ONE;
                        end
                    end
                end
                S_FLUSH: begin
                    ctl = CTL_FLUSH;
                    if (cnt_q == CYC_ONE) begin
                        nxt_state = S_RUN;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt = cnt_q - CYC_ONE;
                    end
                end
                default: begin
                    ctl = CTL_SAFE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= nxt_state;
            cnt_q   <= nxt_cnt;
        end
    end

    // While reset is low the pipe is held frozen with IF/ID and ID/EX forced empty.
    assign pc_en       = reset & ctl[3];
    assign ifid_en     = reset & ctl[2];
    assign ifid_flush  = ~reset | ctl[1];
    assign idex_bubble = ~reset | ctl[0];
    assign state       = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!pc_en && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (ifid_flush && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] id_rn, id_rm, ex_rd;
    logic       id_rn_used, id_rm_used, ex_mem_read, br_taken, ext_stall;

    // Three configurations: defaults; long stall + tiny counters; two-cycle flush.
    logic        a_pc, a_ifid, a_fl, a_bub; logic [1:0] a_st; logic [15:0] a_sc, a_fc;
    logic        b_pc, b_ifid, b_fl, b_bub; logic [1:0] b_st; logic [1:0]  b_sc, b_fc;
    logic        c_pc, c_ifid, c_fl, c_bub; logic [1:0] c_st; logic [15:0] c_sc, c_fc;

    pipeline_hazard_ctrl u_a (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_rn_used(id_rn_used),
        .id_rm_used(id_rm_used), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .br_taken(br_taken),
        .ext_stall(ext_stall), .pc_en(a_pc), .ifid_en(a_ifid), .ifid_flush(a_fl),
        .idex_bubble(a_bub), .state(a_st), .stall_count(a_sc), .flush_count(a_fc));

    pipeline_hazard_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(1), .CNT_W(2)) u_b (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_rn_used(id_rn_used),
        .id_rm_used(id_rm_used), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .br_taken(br_taken),
        .ext_stall(ext_stall), .pc_en(b_pc), .ifid_en(b_ifid), .ifid_flush(b_fl),
        .idex_bubble(b_bub), .state(b_st), .stall_count(b_sc), .flush_count(b_fc));

    pipeline_hazard_ctrl #(.STALL_CYCLES(2), .FLUSH_CYCLES(2)) u_c (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_rn_used(id_rn_used),
        .id_rm_used(id_rm_used), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .br_taken(br_taken),
        .ext_stall(ext_stall), .pc_en(c_pc), .ifid_en(c_ifid), .ifid_flush(c_fl),
        .idex_bubble(c_bub), .state(c_st), .stall_count(c_sc), .flush_count(c_fc));

    int n_cmp = 0;
    int n_bad = 0;

    int scy[3]  = '{1, 3, 2};
    int fcy[3]  = '{1, 1, 2};
    int cmax[3] = '{65535, 3, 65535};

    // Reference: how many more frozen / flushed cycles are owed, plus event counts.
    int m_stall[3], m_flush[3], m_sc[3], m_fc[3];

    typedef struct {
        logic [4:0] rn, rm;
        logic       rnu, rmu, mr;
        logic [4:0] rd;
        logic       br, ext;
        logic       e_pc, e_ifid, e_fl, e_bub;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit hz();
        return ex_mem_read && (ex_rd != 5'd31) &&
               ((id_rn_used && id_rn == ex_rd) || (id_rm_used && id_rm == ex_rd));
    endfunction

    task automatic model_exp(input int i, output int pc, output int ifid, output int fl, output int bub);
        if (br_taken || m_flush[i] > 0) begin
            pc = 1; ifid = 1; fl = 1; bub = 1;
        end else if (m_stall[i] > 0 || ext_stall || hz()) begin
            pc = 0; ifid = 0; fl = 0; bub = 1;
        end else begin
            pc = 1; ifid = 1; fl = 0; bub = 0;
        end
    endtask

    function automatic int model_state(input int i);
        if (m_flush[i] > 0) return 2;
        if (m_stall[i] > 0) return 1;
        return 0;
    endfunction

    task automatic model_adv(input int i);
        int pc, ifid, fl, bub;
        model_exp(i, pc, ifid, fl, bub);
        if (br_taken) begin
            m_flush[i] = fcy[i] - 1;
            m_stall[i] = 0;
        end else if (m_flush[i] > 0) begin
            m_flush[i]--;
        end else if (m_stall[i] > 0) begin
            if (!ext_stall) m_stall[i]--;
        end else if (!ext_stall && hz()) begin
            m_stall[i] = scy[i] - 1;
        end
        if (pc == 0 && m_sc[i] < cmax[i]) m_sc[i]++;
        if (fl == 1 && m_fc[i] < cmax[i]) m_fc[i]++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_stall[i] = 0; m_flush[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end
    endtask

    task automatic get_act(input int i, output int pc, output int ifid, output int fl,
                           output int bub, output int st, output int sc, output int fc);
        case (i)
            0: begin pc = a_pc; ifid = a_ifid; fl = a_fl; bub = a_bub; st = a_st; sc = a_sc; fc = a_fc; end
            1: begin pc = b_pc; ifid = b_ifid; fl = b_fl; bub = b_bub; st = b_st; sc = b_sc; fc = b_fc; end
            default: begin pc = c_pc; ifid = c_ifid; fl = c_fl; bub = c_bub; st = c_st; sc = c_sc; fc = c_fc; end
        endcase
    endtask

    // Check every instance against the model mid-cycle, then clock the model and the DUTs together.
    task automatic step();
        int pc, ifid, fl, bub, ap, ai, af, ab, ast, asc, afc;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            model_exp(i, pc, ifid, fl, bub);
            get_act(i, ap, ai, af, ab, ast, asc, afc);
            chk($sformatf("dut%0d pc_en", i), ap, pc);
            chk($sformatf("dut%0d ifid_en", i), ai, ifid);
            chk($sformatf("dut%0d ifid_flush", i), af, fl);
            chk($sformatf("dut%0d idex_bubble", i), ab, bub);
            chk($sformatf("dut%0d state", i), ast, model_state(i));
            chk($sformatf("dut%0d stall_count", i), asc, m_sc[i]);
            chk($sformatf("dut%0d flush_count", i), afc, m_fc[i]);
        end
        for (int i = 0; i < 3; i++) model_adv(i);
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] rn, input logic [4:0] rm, input logic rnu, input logic rmu,
                          input logic mr, input logic [4:0] rd, input logic br, input logic ext);
        id_rn = rn; id_rm = rm; id_rn_used = rnu; id_rm_used = rmu;
        ex_mem_read = mr; ex_rd = rd; br_taken = br; ext_stall = ext;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_in_reset(input string tag);
        int ap, ai, af, ab, ast, asc, afc;
        for (int i = 0; i < 3; i++) begin
            get_act(i, ap, ai, af, ab, ast, asc, afc);
            chk($sformatf("%s dut%0d pc_en", tag, i), ap, 0);
            chk($sformatf("%s dut%0d ifid_en", tag, i), ai, 0);
            chk($sformatf("%s dut%0d ifid_flush", tag, i), af, 1);
            chk($sformatf("%s dut%0d idex_bubble", tag, i), ab, 1);
            chk($sformatf("%s dut%0d state", tag, i), ast, 0);
            chk($sformatf("%s dut%0d stall_count", tag, i), asc, 0);
            chk($sformatf("%s dut%0d flush_count", tag, i), afc, 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        @(posedge clk);
        #1;
        chk_in_reset("reset");
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        //            rn     rm     rnu   rmu   mr    rd     br    ext    pc    ifid  fl    bub
        vecs[0]  = '{5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{5'd31, 5'd0,  1'b1, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{5'd0,  5'd7,  1'b0, 1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{5'd7,  5'd7,  1'b1, 1'b1, 1'b0, 5'd7,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{5'd1,  5'd2,  1'b1, 1'b1, 1'b1, 5'd3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{5'd5,  5'd5,  1'b1, 1'b1, 1'b1, 5'd5,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        reset = 1'b0;
        idle();
        model_reset();
        do_reset();

        // Default configuration never leaves RUN, so each vector is independent.
        foreach (vecs[k]) begin
            set_in(vecs[k].rn, vecs[k].rm, vecs[k].rnu, vecs[k].rmu, vecs[k].mr, vecs[k].rd,
                   vecs[k].br, vecs[k].ext);
            #1;
            chk($sformatf("vec%0d pc_en", k), a_pc, vecs[k].e_pc);
            chk($sformatf("vec%0d ifid_en", k), a_ifid, vecs[k].e_ifid);
            chk($sformatf("vec%0d ifid_flush", k), a_fl, vecs[k].e_fl);
            chk($sformatf("vec%0d idex_bubble", k), a_bub, vecs[k].e_bub);
            step();
        end

        // Single load-use stall: one frozen cycle then back to running.
        do_reset();
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        step();
        idle();
        #1;
        chk("loaduse pc_en after", a_pc, 1);
        chk("loaduse state after", a_st, 0);
        chk("loaduse stall_count", a_sc, 1);
        step();

        // Three-cycle stall aborted by a branch in its second cycle.
        do_reset();
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        step();
        chk("abort state in stall", b_st, 1);
        idle();
        br_taken = 1'b1;
        #1;
        chk("abort ifid_flush", b_fl, 1);
        chk("abort pc_en", b_pc, 1);
        step();
        idle();
        chk("abort state after", b_st, 0);
        chk("abort stall_count", b_sc, 1);
        chk("abort flush_count", b_fc, 1);
        step();

        // One branch stretches to two flush cycles.
        do_reset();
        br_taken = 1'b1;
        step();
        idle();
        #1;
        chk("flush2 state", c_st, 2);
        chk("flush2 ifid_flush 2nd", c_fl, 1);
        step();
        chk("flush2 flush_count", c_fc, 2);
        chk("flush2 back to run", c_st, 0);

        // Hazard, freeze and branch together: branch action only.
        do_reset();
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
        #1;
        chk("combo pc_en", a_pc, 1);
        chk("combo ifid_flush", a_fl, 1);
        chk("combo idex_bubble", a_bub, 1);
        step();
        chk("combo stall_count", a_sc, 0);

        // Asynchronous reset in the middle of a stall.
        do_reset();
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        step();
        idle();
        #2;
        chk("midreset pre state", b_st, 1);
        chk("midreset pre stall_count", b_sc, 1);
        reset = 1'b0;
        #1;
        chk_in_reset("midreset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();

        // Freeze five cycles: the 2-bit counter saturates at 3.
        ext_stall = 1'b1;
        for (int k = 0; k < 5; k++) step();
        chk("sat b stall_count", b_sc, 3);
        chk("sat a stall_count", a_sc, 5);
        idle();
        step();

        // Randomised traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            if (k % 128 == 127) do_reset();
            id_rn       = 5'($urandom_range(0, 3));
            id_rm       = 5'($urandom_range(0, 3));
            id_rn_used  = 1'($urandom_range(0, 1));
            id_rm_used  = 1'($urandom_range(0, 1));
            ex_mem_read = ($urandom_range(0, 2) != 0);
            ex_rd       = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            br_taken    = ($urandom_range(0, 7) == 0);
            ext_stall   = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
